// File: rtl/speed_cmd_tx_pkg.sv
// Shared types and helpers for the speed-command serial transmitter.
//   tx_state_t       : frame sequencer states
//   DEF_DATA_W       : default speed word width
//   DEF_CLKS_PER_BIT : default bit period in CLK cycles
//   parity_bit()     : parity of a (zero-extended) word, even or odd
package speed_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_CLKS_PER_BIT = 16;

    // Widest word parity_bit() accepts; narrower words are zero-extended,
    // which leaves the XOR unchanged.
    localparam int PAR_MAX_W = 64;

    // odd=0: even parity (XOR of the data), odd=1: its complement.
    function automatic logic parity_bit(input logic [PAR_MAX_W-1:0] word,
                                        input logic                 odd);
        return (^word) ^ odd;
    endfunction

endpackage

// File: rtl/speed_cmd_tx_if.sv
// Load handshake between the speed-word producer and the transmitter.
//   speed_data : speed word offered by the producer
//   load_valid : producer has a word
//   load_ready : transmitter can take a word
// Modports: master = producer side, slave = transmitter side.
interface speed_cmd_tx_if
    import speed_ctrl_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [DATA_W-1:0] speed_data;
    logic              load_valid;
    logic              load_ready;

    modport master (
        output speed_data,
        output load_valid,
        input  load_ready
    );

    modport slave (
        input  speed_data,
        input  load_valid,
        output load_ready
    );

endinterface

// File: rtl/speed_tx_baud_counter.sv
// Bit-period timer for the speed-command transmitter.
// Counts 0..CLKS_PER_BIT-1 while enabled and wraps; bit_end marks the last
// cycle of each bit period.
//   CLK, CLR_BAR : clock, asynchronous active-low clear
//   en           : count while high
//   start        : synchronous clear, aligns the first bit period to a load
//   bit_end      : high on the final count of a bit period
module speed_tx_baud_counter
    import speed_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic CLK,
    input  logic CLR_BAR,
    input  logic en,
    input  logic start,
    output logic bit_end
);

    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign bit_end = en && (cnt == LAST);

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR)
            cnt <= '0;
        else if (start)
            cnt <= '0;
        else if (en)
            cnt <= bit_end ? '0 : cnt + CW'(1);
    end

endmodule

// File: rtl/speed_cmd_tx.sv
// Serial transmitter for speed-command frames.
// Frame: start bit (0), DATA_W data bits LSB first, optional parity bit,
// stop bit (1); each bit held CLKS_PER_BIT cycles. Line idles high.
//   CLK, CLR_BAR : clock, asynchronous active-low reset
//   load_if      : speed_data / load_valid / load_ready handshake (slave)
//   tx_line      : registered serial output
//   busy         : a frame is in progress
//   frame_done   : one-cycle pulse in the first idle cycle after a stop bit
module speed_cmd_tx
    import speed_ctrl_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic           CLK,
    input  logic           CLR_BAR,
    speed_cmd_tx_if.slave  load_if,
    output logic           tx_line,
    output logic           busy,
    output logic           frame_done
);

    localparam int            BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    tx_state_t         state, state_nx;
    logic [DATA_W-1:0] shift_reg, shift_nx;
    logic [BW-1:0]     bit_cnt, bit_nx;
    logic              par, par_nx;
    logic              tx_nx, done_nx;
    logic              accept, bit_end;

    assign load_if.load_ready = (state == IDLE);
    assign accept             = load_if.load_valid && load_if.load_ready;
    assign busy               = (state != IDLE);

    speed_tx_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .CLK     (CLK),
        .CLR_BAR (CLR_BAR),
        .en      (busy),
        .start   (accept),
        .bit_end (bit_end)
    );

    always_ff @(posedge CLK or negedge CLR_BAR) begin
        if (!CLR_BAR) begin
            state      <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            par        <= 1'b0;
            tx_line    <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            shift_reg  <= shift_nx;
            bit_cnt    <= bit_nx;
            par        <= par_nx;
            tx_line    <= tx_nx;
            frame_done <= done_nx;
        end
    end

    // tx_nx is the line level for the state being entered, so tx_line and
    // state change on the same edge.
    always_comb begin
        state_nx = state;
        shift_nx = shift_reg;
        bit_nx   = bit_cnt;
        par_nx   = par;
        tx_nx    = tx_line;
        done_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                tx_nx = 1'b1;
                if (accept) begin
                    state_nx = START;
                    tx_nx    = 1'b0;
                    shift_nx = load_if.speed_data;
                    bit_nx   = '0;
                    par_nx   = parity_bit(PAR_MAX_W'(load_if.speed_data), PARITY_ODD[0]);
                end
            end
            START: begin
                if (bit_end) begin
                    state_nx = DATA;
                    tx_nx    = shift_reg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_nx = shift_reg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_nx = '0;
                        if (PARITY_EN != 0) begin
                            state_nx = PARITY;
                            tx_nx    = par;
                        end else begin
                            state_nx = STOP;
                            tx_nx    = 1'b1;
                        end
                    end else begin
                        bit_nx = bit_cnt + BW'(1);
                        tx_nx  = shift_nx[0];
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_nx = STOP;
                    tx_nx    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_nx = IDLE;
                    tx_nx    = 1'b1;
                    done_nx  = 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
                tx_nx    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_speed_cmd_tx.sv
// Bench for speed_cmd_tx: three instances (even parity, odd parity, no
// parity) with CLKS_PER_BIT=4, each followed cycle by cycle against a model
// that expands every accepted word into its expected line waveform.
module tb_speed_cmd_tx;

    localparam int W = 8;
    localparam int C = 4;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [2:0]   lv    = '0;
    logic [W-1:0] sd [3];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int PEN = (g == 2) ? 0 : 1;
        localparam int ODD = (g == 1) ? 1 : 0;

        speed_cmd_tx_if #(.DATA_W(W)) lif ();
        assign lif.load_valid = lv[g];
        assign lif.speed_data = sd[g];

        logic tx, bsy, done;

        speed_cmd_tx #(
            .DATA_W       (W),
            .CLKS_PER_BIT (C),
            .PARITY_EN    (PEN),
            .PARITY_ODD   (ODD)
        ) dut (
            .CLK        (clk),
            .CLR_BAR    (rst_n),
            .load_if    (lif),
            .tx_line    (tx),
            .busy       (bsy),
            .frame_done (done)
        );

        // Model: expected level for each upcoming cycle sits in q.
        bit   q[$];
        logic m_tx   = 1'b1;
        logic m_busy = 1'b0;
        logic m_done = 1'b0;

        initial begin
            bit       b;
            bit       rdy;
            bit [7:0] d;
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    q.delete();
                    m_tx   = 1'b1;
                    m_busy = 1'b0;
                    m_done = 1'b0;
                end else begin
                    rdy    = !m_busy;
                    m_done = 1'b0;
                    if (rdy && lv[g]) begin
                        d = sd[g];
                        for (int s = 0; s < 2 + W + PEN; s++) begin
                            if (s == 0)                 b = 1'b0;
                            else if (s <= W)            b = d[s-1];
                            else if (PEN != 0 && s == W + 1)
                                b = (^d) ^ (ODD != 0);
                            else                        b = 1'b1;
                            repeat (C) q.push_back(b);
                        end
                    end
                    if (q.size() > 0) begin
                        m_tx   = q.pop_front();
                        m_busy = 1'b1;
                    end else begin
                        m_done = m_busy;
                        m_busy = 1'b0;
                        m_tx   = 1'b1;
                    end
                end
            end
        end

        initial begin
            forever begin
                @(negedge clk);
                chk($sformatf("d%0d_tx", g),    tx,             m_tx);
                chk($sformatf("d%0d_busy", g),  bsy,            m_busy);
                chk($sformatf("d%0d_ready", g), lif.load_ready, !m_busy);
                chk($sformatf("d%0d_done", g),  done,           m_done);
            end
        end
    end

    initial begin
        int first_done0, first_done2;

        sd[0] = '0; sd[1] = '0; sd[2] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx",    u[0].tx, 1);
        chk("rst_ready", u[0].lif.load_ready, 1);
        chk("rst_busy",  u[0].bsy, 0);
        chk("rst_done",  u[0].done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame 0xA5 (even), 0x01 (odd / no parity); frame_done latency
        sd[0] = 8'hA5; sd[1] = 8'h01; sd[2] = 8'h01;
        lv = 3'b111;
        first_done0 = 0;
        first_done2 = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (n == 1) lv = '0;
            if (u[0].done && first_done0 == 0) first_done0 = n;
            if (u[2].done && first_done2 == 0) first_done2 = n;
        end
        chk("lat_par",   first_done0, (2 + W + 1) * C + 1);
        chk("lat_nopar", first_done2, (2 + W) * C + 1);

        // Back-to-back with load_valid held; word changes after first accept
        sd[0] = 8'h3C; sd[1] = 8'h3C; sd[2] = 8'h3C;
        lv = 3'b111;
        repeat (2) @(negedge clk);
        sd[0] = 8'hFF; sd[1] = 8'hFF; sd[2] = 8'hFF;
        repeat (48) @(negedge clk);
        lv = '0;
        repeat (50) @(negedge clk);

        // Load attempt while busy is dropped
        sd[0] = 8'h96; lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (10) @(negedge clk);
        sd[0] = 8'h55; lv[0] = 1'b1;
        @(negedge clk);
        lv[0] = 1'b0;
        repeat (50) @(negedge clk);

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lv[g] = ($urandom_range(0, 7) == 0);
                sd[g] = W'($urandom);
            end
        end
        lv = '0;
        repeat (50) @(negedge clk);

        // Reset during data bit 3
        sd[0] = 8'hC3; sd[1] = 8'h5A; sd[2] = 8'h0F;
        lv = 3'b111;
        @(negedge clk);
        lv = '0;
        repeat (17) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_tx0",   u[0].tx, 1);
        chk("mrst_tx1",   u[1].tx, 1);
        chk("mrst_tx2",   u[2].tx, 1);
        chk("mrst_busy0", u[0].bsy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        sd[0] = 8'h81; sd[1] = 8'h7E; sd[2] = 8'hE7;
        lv = 3'b111;
        @(negedge clk);
        lv = '0;
        repeat (55) @(negedge clk);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
